dm_access_unit: RTL

Multi-cycle data-memory access unit between the pipelined CPU's MEM stage and a word-organised data RAM with a ready handshake.
- Takes the CPU's byte address, store data, DMType and read/write strobes.
- Drives byte-enabled word accesses to the RAM.
- Returns sign/zero-extended load data.
- Holds the pipeline through `cpu_stall` until the RAM answers or a timeout fires.

---
 rtl/dm_pkg.sv | 39 +++
 rtl/dm_access_unit_if.sv | 37 +++
 rtl/dm_lane_fmt.sv | 57 +++++
 rtl/dm_access_unit.sv | 121 ++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared DMType codes, FSM state encoding and access-size helpers for the data-memory access unit.
package dm_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_t;

    // Codes 101-111 have no meaning of their own and fall back to a word access.
    function automatic size_t dm_size(input logic [2:0] dmtype);
        case (dmtype)
            DM_HALF, DM_HALF_U: dm_size = SZ_HALF;
            DM_BYTE, DM_BYTE_U: dm_size = SZ_BYTE;
            default:            dm_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic dm_aligned(input size_t size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: dm_aligned = ~addr_lo[0];
            SZ_BYTE: dm_aligned = 1'b1;
            default: dm_aligned = (addr_lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// CPU-side and RAM-side signal bundle of the data-memory access unit.
interface dm_access_unit_if;

    // CPU side: a request (cpu_we | cpu_re) is held until cpu_stall drops; RAM side: ram_req is
    // the valid, ram_ready the ready, and a transfer completes on a cycle where both are high.
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_dmtype;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        err;

    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_we;
    logic        ram_req;
    logic [31:0] ram_rdata;
    logic        ram_ready;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_dmtype, cpu_we, cpu_re,
        output cpu_rdata, cpu_stall, err,
        output ram_addr, ram_wdata, ram_be, ram_we, ram_req,
        input  ram_rdata, ram_ready
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_dmtype, cpu_we, cpu_re,
        input  cpu_rdata, cpu_stall, err,
        input  ram_addr, ram_wdata, ram_be, ram_we, ram_req,
        output ram_rdata, ram_ready
    );

endinterface

// File: rtl/dm_lane_fmt.sv
// Byte-lane formatting: store byte enables and lane replication, load lane extraction and extension.
module dm_lane_fmt
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  size_t       size,
    input  logic [31:0] wdata,
    input  logic [2:0]  dmtype,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_fmt
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    always_comb begin
        lane_b = rdata[7:0];
        case (addr_lo)
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            2'd3:    lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        rdata_fmt = rdata;
        case (dmtype)
            DM_HALF:   rdata_fmt = {{16{lane_h[15]}}, lane_h};
            DM_HALF_U: rdata_fmt = {16'h0000, lane_h};
            DM_BYTE:   rdata_fmt = {{24{lane_b[7]}}, lane_b};
            DM_BYTE_U: rdata_fmt = {24'h000000, lane_b};
            default:   rdata_fmt = rdata;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Multi-cycle data-memory access unit: stalls the MEM stage while one byte-enabled word access
// runs against a ready-handshake RAM, flagging misaligned requests and RAM timeouts on err.
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    dm_access_unit_if.slave bus,
    output state_t          dbg_state
);

    localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);
    localparam logic [4:0] CNT_MAX  = 5'h1f;

    state_t      state, state_nx;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  dmtype_q;
    logic        we_q, err_q;
    logic [4:0]  cnt;

    logic        req, aligned, accept, misaligned, timeout;
    logic        stall_c, ram_req_c;
    size_t       size_q;
    logic [3:0]  be;
    logic [31:0] wdata_rep, rdata_fmt;

    assign req        = bus.cpu_we | bus.cpu_re;
    assign aligned    = dm_aligned(dm_size(bus.cpu_dmtype), bus.cpu_addr[1:0]);
    assign accept     = (state == S_IDLE) && req && aligned;
    assign misaligned = (state == S_IDLE) && req && !aligned;
    assign timeout    = (state == S_REQ) && !bus.ram_ready && (cnt == CNT_LAST);
    assign size_q     = dm_size(dmtype_q);

    dm_lane_fmt u_fmt (
        .addr_lo   (addr_q[1:0]),
        .size      (size_q),
        .wdata     (wdata_q),
        .dmtype    (dmtype_q),
        .rdata     (bus.ram_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_fmt (rdata_fmt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        stall_c   = 1'b0;
        ram_req_c = 1'b0;
        case (state)
            S_IDLE: begin
                stall_c = accept;
                if (accept) state_nx = S_REQ;
            end
            S_REQ: begin
                stall_c   = 1'b1;
                ram_req_c = 1'b1;
                if (bus.ram_ready || timeout) state_nx = S_DONE;
            end
            // The request still visible on the CPU side here is the one just served.
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            dmtype_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt      <= '0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                addr_q   <= bus.cpu_addr;
                wdata_q  <= bus.cpu_wdata;
                dmtype_q <= bus.cpu_dmtype;
                we_q     <= bus.cpu_we;
                cnt      <= '0;
            end
            if (misaligned) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
            if (state == S_REQ) begin
                if (bus.ram_ready) begin
                    if (!we_q) rdata_q <= rdata_fmt;
                end else if (timeout) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + 5'd1;
                end
            end
        end
    end

    // Stall is gated by reset so a request held across reset cannot keep the pipeline frozen.
    assign bus.cpu_stall = stall_c && !reset;
    assign bus.ram_req   = ram_req_c && !reset;
    assign bus.ram_be    = ram_req_c ? be : 4'b0000;
    assign bus.ram_we    = ram_req_c && we_q;
    assign bus.ram_addr  = addr_q[31:2];
    assign bus.ram_wdata = wdata_rep;
    assign bus.cpu_rdata = rdata_q;
    assign bus.err       = err_q;
    assign dbg_state     = state;

endmodule
